// File: rtl/universal_counter_n.sv
// rtl/universal_counter_n.sv - loadable up/down counter with a programmable terminal value and cascade carry
// Vectors are MSB-first ([0:WIDTH-1]); arithmetic is unsigned.
module universal_counter_n #(
  parameter int WIDTH = 8,
  parameter int SAT   = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [0:WIDTH-1] D,
  input  logic [0:WIDTH-1] LIMIT,
  input  logic             CIN,
  input  logic [0:1]       SEL,
  output logic [0:WIDTH-1] Q,
  output logic             COUT,
  output logic             TC
);

  localparam logic [0:1] SEL_LOAD = 2'b00;
  localparam logic [0:1] SEL_DEC  = 2'b01;
  localparam logic [0:1] SEL_INC  = 2'b10;
  localparam logic [0:1] SEL_HOLD = 2'b11;

  localparam logic [0:WIDTH-1] ZERO = '0;
  localparam logic [0:WIDTH-1] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:WIDTH-1] q_q, q_d;
  logic             cout_q, cout_d;
  logic             at_limit, at_zero;

  assign at_limit = (q_q == LIMIT);
  assign at_zero  = (q_q == ZERO);

  // Lookahead terminal count lets the next stage count on the same edge.
  assign TC = CIN & (((SEL == SEL_INC) & at_limit) | ((SEL == SEL_DEC) & at_zero));

  always_comb begin
    q_d    = q_q;
    cout_d = cout_q;
    case (SEL)
      SEL_LOAD: begin
        q_d    = D;
        cout_d = 1'b1;
      end
      SEL_DEC: begin
        if (!CIN) begin
          cout_d = 1'b0;
        end else if (at_zero) begin
          cout_d = 1'b1;
          q_d    = (SAT != 0) ? q_q : LIMIT;
        end else begin
          q_d    = q_q - ONE;
          cout_d = 1'b0;
        end
      end
      SEL_INC: begin
        // Above LIMIT (after a load) the count simply rolls through all-ones silently.
        if (!CIN) begin
          cout_d = 1'b0;
        end else if (at_limit) begin
          cout_d = 1'b1;
          q_d    = (SAT != 0) ? q_q : ZERO;
        end else begin
          q_d    = q_q + ONE;
          cout_d = 1'b0;
        end
      end
      SEL_HOLD: begin
        q_d    = q_q;
        cout_d = cout_q;
      end
      default: begin
        q_d    = q_q;
        cout_d = cout_q;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_q    <= ZERO;
      cout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cout_q <= cout_d;
    end
  end

  assign Q    = q_q;
  assign COUT = cout_q;

endmodule

// File: doc/universal_counter_n.md
UNIVERSAL_COUNTER_N -- requirements
Module: universal_counter_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter width in bits (legal range 2..36).
REQ-002 The block SHALL have parameter SAT, default 0, boundary mode: 0 = wrap (modulo), 1 = saturate.
REQ-003 The block SHALL have port CLK  input  1  rising-edge clock.
REQ-004 The block SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port D  input  [0:WIDTH-1]  parallel load value.
REQ-006 The block SHALL have port LIMIT  input  [0:WIDTH-1]  terminal value; count range is 0..LIMIT.
REQ-007 The block SHALL have port CIN  input  1  count enable / cascade carry-in.
REQ-008 The block SHALL have port SEL  input  [0:1]  mode: 00 LOAD, 01 DEC, 10 INC, 11 HOLD.
REQ-009 The block SHALL have port Q  output  [0:WIDTH-1]  registered count.
REQ-010 The block SHALL have port COUT  output  1  registered carry/borrow, valid the cycle after the event.
REQ-011 The block SHALL have port TC  output  1  combinational lookahead terminal count for same-cycle cascading.
REQ-012 All vectors SHALL use bit 0 as MSB; arithmetic is unsigned.

Function
REQ-013 LOAD (SEL=00) SHALL set Q<=D and COUT<=1 on the clock edge regardless of CIN or LIMIT.
REQ-014 HOLD (SEL=11) SHALL retain Q and COUT unchanged regardless of CIN.
REQ-015 INC/DEC with CIN=0 SHALL retain Q and set COUT<=0.
REQ-016 INC with CIN=1 and Q!=LIMIT SHALL set Q<=Q+1 (mod 2^WIDTH) and COUT<=0.
REQ-017 INC with CIN=1 and Q==LIMIT SHALL set COUT<=1 and Q<=0 when SAT=0, or retain Q when SAT=1.
REQ-018 DEC with CIN=1 and Q!=0 SHALL set Q<=Q-1 and COUT<=0.
REQ-019 DEC with CIN=1 and Q==0 SHALL set COUT<=1 and Q<=LIMIT when SAT=0, or retain Q=0 when SAT=1.
REQ-020 If Q>LIMIT (after LOAD), INC SHALL count upward without a terminal event through all-ones, wrapping to 0 with COUT<=0; the LIMIT test then applies normally.
REQ-021 TC SHALL equal CIN & ((SEL==10 & Q==LIMIT) | (SEL==01 & Q==0)), purely combinational from current inputs and Q, zero-cycle latency.
REQ-022 TC SHALL be 0 for SEL=00 and SEL=11.
REQ-023 LIMIT SHALL be sampled combinationally each cycle; a LIMIT change takes effect on the next edge with no internal latching.
REQ-024 LIMIT = all-ones, SAT=0 SHALL give plain binary modulo-2^WIDTH up/down behaviour.
REQ-025 Cascading SHALL be supported by wiring TC of a lower stage to CIN of the next stage with common SEL and CLK; no extra logic between stages.

Reset
REQ-026 RESET=1 SHALL force Q=0 and COUT=0 immediately, independent of CLK.
REQ-027 While RESET=1, clock edges SHALL have no effect; TC SHALL still follow REQ-021 with Q=0.
REQ-028 On RESET deassertion the first active edge SHALL operate per SEL from Q=0, COUT=0.
REQ-029 RESET asserted mid-count SHALL abandon the count with no COUT pulse.

Verification
REQ-030 WIDTH=8, SAT=0, LIMIT=9: LOAD D=7, then INC CIN=1 x4 -> Q=8,9,0,1; COUT=0,0,1,0; TC=1 only in the cycle Q=9.
REQ-031 WIDTH=8, SAT=0, LIMIT=9: LOAD D=1, DEC CIN=1 x3 -> Q=0,9,8; COUT=0,1,0.
REQ-032 WIDTH=8, SAT=1, LIMIT=0xFF: LOAD 0xFE, INC x3 -> Q=0xFF,0xFF,0xFF; COUT=0,1,1.
REQ-033 Two WIDTH=4 stages cascaded, LIMIT=0xF, SEL=INC, low CIN=1 from Q=0x00: after 16 edges, high Q=1, low Q=0; after 256 edges, both 0.
REQ-034 Q=0x55, INC running: assert RESET between edges -> Q=0, COUT=0 before next edge; with SEL=HOLD, CIN=1, then deassert -> Q stays 0.
REQ-035 LOAD D=0x20 with LIMIT=0x10, INC CIN=1 -> Q increments 0x21.. to 0xFF, then 0x00 with COUT=0, then TC=1 at Q=0x10.
